// File: rtl/sram_controller.sv
// ============================================================================
// Module   : sram_controller
// Purpose  : 32-bit MEM-stage access sequencer for a 16-bit asynchronous SRAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_controller #(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic [17:0] o_sram_addr,
    output logic [15:0] o_sram_dq_out,
    output logic        o_sram_dq_oe,
    input  logic [15:0] i_sram_dq_in,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_is_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;
    logic        w_req;
    logic        w_last;
    logic        w_active;
    logic [31:0] w_offset;
    logic [16:0] w_word;

    assign w_req    = i_rd_en | i_wr_en;
    assign w_last   = (r_cnt == c_LAST);
    assign w_active = (r_state == S_LOW) || (r_state == S_HIGH);
    assign w_offset = r_addr - ADDR_BASE;
    assign w_word   = 17'(w_offset >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture, wait counter and read assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_is_wr     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_wr <= i_wr_en;
                        r_addr  <= i_address;
                        r_wdata <= i_write_data;
                        r_cnt   <= 4'd0;
                    end
                end
                S_LOW, S_HIGH: begin
                    if (w_last) begin
                        r_cnt <= 4'd0;
                        if (!r_is_wr) begin
                            if (r_state == S_LOW) begin
                                r_read_data[15:0] <= i_sram_dq_in;
                            end else begin
                                r_read_data[31:16] <= i_sram_dq_in;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        o_sram_addr   = 18'd0;
        o_sram_dq_out = 16'd0;
        o_sram_dq_oe  = 1'b0;
        o_sram_ce_n   = 1'b1;
        o_sram_oe_n   = 1'b1;
        o_sram_we_n   = 1'b1;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_LOW;
            S_LOW:   if (w_last) w_next = S_HIGH;
            S_HIGH:  if (w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (w_active) begin
            o_sram_addr = {w_word, (r_state == S_HIGH)};
            o_sram_ce_n = 1'b0;
            if (r_is_wr) begin
                o_sram_dq_oe  = 1'b1;
                o_sram_dq_out = (r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
                // we_n rises on the last cycle so address/data straddle the edge
                o_sram_we_n   = w_last;
            end else begin
                o_sram_oe_n = 1'b0;
            end
        end
    end

    assign o_read_data = r_read_data;
    assign o_ready     = ~w_req | (r_state == S_DONE);
    assign o_sram_ub_n = 1'b0;
    assign o_sram_lb_n = 1'b0;

endmodule

`default_nettype wire
